// File: rtl/opb_master_single.sv
// Single-beat OPB bus master: takes one read or write command at a time from user logic
// and reports read data plus a completion status (ok, errAck, timeout, retries exhausted).
module opb_master_single #(
  parameter int C_OPB_AWIDTH     = 32,
  parameter int C_OPB_DWIDTH     = 32,
  parameter int C_TIMEOUT_CYCLES = 16,
  parameter int C_MAX_RETRIES    = 4
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  output logic                    M_request,
  output logic                    M_busLock,
  output logic                    M_select,
  output logic                    M_RNW,
  output logic [0:3]              M_BE,
  output logic                    M_seqAddr,
  output logic [0:C_OPB_AWIDTH-1] M_ABus,
  output logic [0:C_OPB_DWIDTH-1] M_DBus,
  input  logic                    OPB_MGrant,
  input  logic                    OPB_xferAck,
  input  logic                    OPB_errAck,
  input  logic                    OPB_retry,
  input  logic                    OPB_toutSup,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_rnw,
  input  logic [31:0]             cmd_addr,
  input  logic [31:0]             cmd_wdata,
  input  logic [3:0]              cmd_be,
  output logic                    rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic [1:0]              rsp_status
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_BACKOFF,
    S_RESP
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_RETRY   = 2'b11;

  localparam logic [3:0] MaxRetries  = 4'(C_MAX_RETRIES);
  localparam logic [7:0] TimeoutLast = 8'(C_TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        rnw_q, rnw_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [3:0]  retry_q, retry_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  status_q, status_d;

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q  <= S_IDLE;
      rnw_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      retry_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      rnw_q    <= rnw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      retry_q  <= retry_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
    end
  end

  // Resolution priority in XFER: errAck, then xferAck, then retry, then timeout.
  always_comb begin
    state_d  = state_q;
    rnw_d    = rnw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    retry_d  = retry_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          rnw_d   = cmd_rnw;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          be_d    = cmd_be;
          retry_d = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = '0;
        if (OPB_MGrant) state_d = S_XFER;
      end
      S_XFER: begin
        if (!OPB_toutSup) cnt_d = cnt_q + 8'd1;
        if (OPB_errAck) begin
          status_d = ST_ERR;
          rdata_d  = '0;
          state_d  = S_RESP;
        end else if (OPB_xferAck) begin
          status_d = ST_OK;
          rdata_d  = rnw_q ? 32'(OPB_DBus) : 32'd0;
          state_d  = S_RESP;
        end else if (OPB_retry) begin
          if (retry_q < MaxRetries) begin
            retry_d = retry_q + 4'd1;
            state_d = S_BACKOFF;
          end else begin
            status_d = ST_RETRY;
            rdata_d  = '0;
            state_d  = S_RESP;
          end
        end else if (cnt_q == TimeoutLast && !OPB_toutSup) begin
          status_d = ST_TIMEOUT;
          rdata_d  = '0;
          state_d  = S_RESP;
        end
      end
      S_BACKOFF: state_d = S_REQ;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Address/data phase signals are gated to zero off-select so the OR-bus stays clean.
  assign M_busLock  = 1'b0;
  assign M_seqAddr  = 1'b0;
  assign M_request  = (state_q == S_REQ);
  assign M_select   = (state_q == S_XFER);
  assign M_RNW      = M_select & rnw_q;
  assign M_BE       = M_select ? be_q : 4'd0;
  assign M_ABus     = M_select ? C_OPB_AWIDTH'(addr_q) : '0;
  assign M_DBus     = (M_select && !rnw_q) ? C_OPB_DWIDTH'(wdata_q) : '0;
  assign cmd_ready  = (state_q == S_IDLE) && !OPB_Rst;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_rdata  = rsp_valid ? rdata_q : 32'd0;
  assign rsp_status = rsp_valid ? status_q : 2'd0;

endmodule

// File: tb/tb_opb_master_single.sv
// Directed bench for opb_master_single: a scripted OPB slave/arbiter answers each command
// and every observation is compared against hand-computed expectations.
module tb_opb_master_single;

  logic        clk = 1'b0;
  logic        OPB_Rst;
  logic        M_request, M_busLock, M_select, M_RNW, M_seqAddr;
  logic [0:3]  M_BE;
  logic [0:31] M_ABus, M_DBus;
  logic        OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup;
  logic [0:31] OPB_DBus;
  logic        cmd_valid, cmd_ready, cmd_rnw;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;

  int compareCount = 0;
  int mismatchCount = 0;

  opb_master_single #(
    .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32), .C_TIMEOUT_CYCLES(16), .C_MAX_RETRIES(4)
  ) dut (
    .OPB_Clk(clk), .OPB_Rst(OPB_Rst),
    .M_request(M_request), .M_busLock(M_busLock), .M_select(M_select), .M_RNW(M_RNW),
    .M_BE(M_BE), .M_seqAddr(M_seqAddr), .M_ABus(M_ABus), .M_DBus(M_DBus),
    .OPB_MGrant(OPB_MGrant), .OPB_xferAck(OPB_xferAck), .OPB_errAck(OPB_errAck),
    .OPB_retry(OPB_retry), .OPB_toutSup(OPB_toutSup), .OPB_DBus(OPB_DBus),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearSlave();
    OPB_MGrant  = 1'b0;
    OPB_xferAck = 1'b0;
    OPB_errAck  = 1'b0;
    OPB_retry   = 1'b0;
    OPB_toutSup = 1'b0;
    OPB_DBus    = '0;
  endtask

  // Issues one command at a negedge and plays arbiter/slave cycle by cycle.
  // grantDelay: request cycles before grant on the first attempt (later attempts immediate).
  // ackCycle: select cycle of the final attempt that acks (0 = never).
  // retries: number of attempts answered with retry in their first select cycle.
  task automatic applyStimulus(
    input string tag, input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
    input logic [3:0] be, input int grantDelay, input int ackCycle, input int retries,
    input logic withErr, input int toutSupCycles, input logic [31:0] slaveData,
    input int expReq, input int expSel, input int expBackoff,
    input logic [1:0] expStatus, input logic [31:0] expRdata);
    int attempt = 1, selIdx = 0, reqIdx = 0, cycles = 0;
    int reqTotal = 0, selTotal = 0, backoffs = 0, hygErr = 0, selErr = 0;
    logic prevSel = 1'b0, done = 1'b0;
    logic [1:0] gotStatus = '0;
    logic [31:0] gotRdata = '0;
    checkOutput({tag, ".readyBefore"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_wdata = wdata; cmd_be = be;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
    while (!done && cycles < 200) begin
      clearSlave();
      if (cmd_ready || M_busLock || M_seqAddr || (M_request && M_select)) hygErr++;
      if (!M_select && ({M_ABus, M_DBus, M_BE, M_RNW} != '0)) hygErr++;
      if (rsp_valid) begin
        gotStatus = rsp_status;
        gotRdata  = rsp_rdata;
        done = 1'b1;
      end else if (M_request) begin
        reqIdx++; reqTotal++;
        if (attempt > 1 || reqIdx >= grantDelay) OPB_MGrant = 1'b1;
      end else if (M_select) begin
        selIdx++; selTotal++;
        if (M_ABus !== addr || M_RNW !== rnw || M_BE !== be || M_DBus !== (rnw ? 32'd0 : wdata))
          selErr++;
        if (selTotal <= toutSupCycles) OPB_toutSup = 1'b1;
        if (attempt <= retries && selIdx == 1) OPB_retry = 1'b1;
        else if (ackCycle != 0 && selIdx == ackCycle) begin
          OPB_xferAck = 1'b1;
          OPB_errAck  = withErr;
          OPB_DBus    = slaveData;
        end
      end else if (prevSel) begin
        backoffs++; attempt++; selIdx = 0;
      end else hygErr++;
      prevSel = M_select;
      cycles++;
      if (!done) @(negedge clk);
    end
    clearSlave();
    checkOutput({tag, ".rspSeen"}, {31'd0, done}, 32'd1);
    checkOutput({tag, ".status"}, {30'd0, gotStatus}, {30'd0, expStatus});
    checkOutput({tag, ".rdata"}, gotRdata, expRdata);
    checkOutput({tag, ".reqCycles"}, reqTotal, expReq);
    checkOutput({tag, ".selCycles"}, selTotal, expSel);
    checkOutput({tag, ".backoffs"}, backoffs, expBackoff);
    checkOutput({tag, ".selectBus"}, selErr, 0);
    checkOutput({tag, ".hygiene"}, hygErr, 0);
    @(negedge clk);
    checkOutput({tag, ".postRsp"},
                {28'd0, rsp_valid, cmd_ready, |rsp_status, |rsp_rdata}, 32'd4);
  endtask

  initial begin
    int rspCount;
    OPB_Rst = 1'b1;
    cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
    clearSlave();
    repeat (2) @(negedge clk);
    checkOutput("resetOutputs",
                {23'd0, M_request, M_busLock, M_select, M_RNW, M_seqAddr, cmd_ready, rsp_valid,
                 |M_BE, |{M_ABus, M_DBus, rsp_rdata, rsp_status}}, 32'd0);
    OPB_Rst = 1'b0;
    @(negedge clk);
    checkOutput("readyAfterReset", {31'd0, cmd_ready}, 32'd1);

    $display("[TB] read, immediate grant, ack in 2nd select cycle");
    applyStimulus("read", 1'b1, 32'h0104_0000, 32'h0, 4'hF, 1, 2, 0, 1'b0, 0, 32'hDEAD_BEEF,
                  1, 2, 0, 2'b00, 32'hDEAD_BEEF);

    $display("[TB] write, grant after 5 request cycles");
    applyStimulus("write", 1'b0, 32'h0000_0100, 32'h1234_5678, 4'b0011, 5, 1, 0, 1'b0, 0,
                  32'hFFFF_FFFF, 5, 1, 0, 2'b00, 32'h0);

    $display("[TB] five retries exhaust the budget of four");
    applyStimulus("retryFail", 1'b1, 32'h0000_0200, 32'h0, 4'hF, 1, 1, 5, 1'b0, 0,
                  32'h1111_1111, 5, 5, 4, 2'b11, 32'h0);

    $display("[TB] four retries then ack still succeeds");
    applyStimulus("retryOk", 1'b1, 32'h0000_0204, 32'h0, 4'hF, 1, 1, 4, 1'b0, 0,
                  32'hCAFE_0004, 5, 5, 4, 2'b00, 32'hCAFE_0004);

    $display("[TB] no slave response -> timeout");
    applyStimulus("timeout", 1'b1, 32'h0000_0300, 32'h0, 4'hF, 1, 0, 0, 1'b0, 0,
                  32'h0, 1, 16, 0, 2'b10, 32'h0);

    $display("[TB] timeout with toutSup held for 10 cycles");
    applyStimulus("timeoutSup", 1'b0, 32'h0000_0304, 32'hA5A5_A5A5, 4'b1100, 1, 0, 0, 1'b0, 10,
                  32'h0, 1, 26, 0, 2'b10, 32'h0);

    $display("[TB] errAck together with xferAck");
    applyStimulus("errAck", 1'b1, 32'h0000_0400, 32'h0, 4'hF, 1, 1, 0, 1'b1, 0,
                  32'hAAAA_5555, 1, 1, 0, 2'b01, 32'h0);

    $display("[TB] reset pulsed during XFER");
    cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 32'h0000_0500; cmd_be = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0; OPB_MGrant = 1'b1;
    @(negedge clk);
    OPB_MGrant = 1'b0;
    checkOutput("rstPreSelect", {31'd0, M_select}, 32'd1);
    OPB_Rst = 1'b1;
    @(negedge clk);
    checkOutput("rstOutputs",
                {24'd0, M_request, M_select, M_RNW, |M_BE, |M_ABus, |M_DBus, rsp_valid, cmd_ready},
                32'd0);
    OPB_Rst = 1'b0;
    @(negedge clk);
    checkOutput("rstReadyAfter", {31'd0, cmd_ready}, 32'd1);
    rspCount = 0;
    repeat (5) begin
      if (rsp_valid || M_request || M_select) rspCount++;
      @(negedge clk);
    end
    checkOutput("rstNoActivity", rspCount, 0);
    applyStimulus("afterRst", 1'b1, 32'h0000_0600, 32'h0, 4'b1010, 1, 1, 0, 1'b0, 0,
                  32'h0BAD_F00D, 1, 1, 0, 2'b00, 32'h0BAD_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
